// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch front end, the instruction cache and decode.
// The master side is the fetch_queue; the slave side is the cache/decode environment.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int FETCH_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0]    entry;
  logic                     redirect_valid;
  logic [ADDR_WIDTH-1:0]    redirect_target;
  logic                     icache_req_valid;
  logic                     icache_req_ready;
  logic [ADDR_WIDTH-1:0]    icache_req_addr;
  logic                     icache_resp_valid;
  logic [32*FETCH_WIDTH-1:0] icache_resp_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_WIDTH-1:0]    out_pc;
  logic [31:0]              out_instr;

  modport master (
    input  entry, redirect_valid, redirect_target,
    input  icache_req_ready, icache_resp_valid, icache_resp_data,
    input  out_ready,
    output icache_req_valid, icache_req_addr,
    output out_valid, out_pc, out_instr
  );

  modport slave (
    output entry, redirect_valid, redirect_target,
    output icache_req_ready, icache_resp_valid, icache_resp_data,
    output out_ready,
    input  icache_req_valid, icache_req_addr,
    input  out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: requests aligned blocks of FETCH_WIDTH
// instructions from the I-cache, enqueues the useful slots into a
// QUEUE_DEPTH-entry queue and hands them to decode one per cycle.
// A single request is outstanding at a time; a redirect during an
// in-flight request marks its response to be discarded.
module fetch_queue #(
  parameter int ADDR_WIDTH  = 64,
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ADDR_WIDTH'(4*FETCH_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_BYTES = ADDR_WIDTH'(4*FETCH_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(3);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                 state_q;
  logic                   drop_q;
  logic                   req_valid_q;
  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;

  logic [ADDR_WIDTH-1:0]  pc_mem    [QUEUE_DEPTH];
  logic [31:0]            instr_mem [QUEUE_DEPTH];

  logic [ADDR_WIDTH-1:0]  blk_addr;
  logic [SLOT_W-1:0]      offset;
  logic [CNT_W-1:0]       n_push;
  logic                   push;
  logic                   pop;
  logic                   req_fire;
  logic                   free_ok_d;
  logic                   head_valid;

  assign blk_addr   = fetch_pc_q & ~BLK_MASK;
  assign offset     = SLOT_W'((fetch_pc_q >> 2) & ADDR_WIDTH'(FETCH_WIDTH - 1));
  assign n_push     = CNT_W'(FETCH_WIDTH) - CNT_W'(offset);
  assign head_valid = (count_q != '0);
  assign pop        = head_valid && bus.out_ready;
  assign req_fire   = req_valid_q && bus.icache_req_ready;
  assign push       = (state_q == WAIT) && bus.icache_resp_valid && !drop_q
                      && !bus.redirect_valid;
  assign free_ok_d  = (CNT_W'(QUEUE_DEPTH) - count_d) >= CNT_W'(FETCH_WIDTH);

  assign bus.icache_req_valid = req_valid_q;
  assign bus.icache_req_addr  = req_addr_q;
  assign bus.out_valid        = head_valid;
  assign bus.out_pc           = head_valid ? pc_mem[rd_ptr_q]    : '0;
  assign bus.out_instr        = head_valid ? instr_mem[rd_ptr_q] : '0;

  // Next queue occupancy, pointers and fetch PC; a redirect flushes the queue.
  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = bus.redirect_target & ~WORD_MASK;
    end else begin
      count_d  = count_q + (push ? n_push : '0) - (pop ? CNT_W'(1) : '0);
      rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(1) : '0);
      wr_ptr_d = wr_ptr_q + (push ? PTR_W'(n_push) : '0);
      if (push) fetch_pc_d = blk_addr + BLK_BYTES;
    end
  end

  // Queue bookkeeping registers and the fetch PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= bus.entry & ~WORD_MASK;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Queue storage: slots from the current offset upward land in consecutive entries.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        if (s >= int'(offset)) begin
          pc_mem[wr_ptr_q + PTR_W'(s) - PTR_W'(offset)]    <= blk_addr + ADDR_WIDTH'(4*s);
          instr_mem[wr_ptr_q + PTR_W'(s) - PTR_W'(offset)] <= bus.icache_resp_data[32*s +: 32];
        end
      end
    end
  end

  // Request FSM with registered request valid/address; redirect has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      req_addr_q <= fetch_pc_d & ~BLK_MASK;
      if (bus.redirect_valid) begin
        if ((state_q == WAIT && !bus.icache_resp_valid) ||
            (state_q == REQ && req_fire)) begin
          state_q     <= WAIT;
          drop_q      <= 1'b1;
          req_valid_q <= 1'b0;
        end else begin
          state_q     <= REQ;
          drop_q      <= 1'b0;
          req_valid_q <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= REQ;
            req_valid_q <= free_ok_d;
          end
          REQ: begin
            if (req_fire) begin
              state_q     <= WAIT;
              drop_q      <= 1'b0;
              req_valid_q <= 1'b0;
            end else begin
              req_valid_q <= free_ok_d;
            end
          end
          WAIT: begin
            if (bus.icache_resp_valid) begin
              state_q     <= REQ;
              drop_q      <= 1'b0;
              req_valid_q <= free_ok_d;
            end
          end
          default: begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
